// File: rtl/systolic_feeder.sv
// ---------------------------------------------------------------------------
// systolic_feeder
//
// Holds one A tile and one B tile (SIZE x SIZE elements of DW bits each,
// written one element at a time while idle). On i_start, it streams the
// tiles into a SIZE x SIZE systolic MAC array in skewed wavefront order:
// row i of A is delayed i cycles and column j of B is delayed j cycles, with
// a valid flag per lane. It then waits DRAIN cycles for the array to finish
// accumulating and pulses o_done for one cycle.
//
// Ports
//   i_clk        clock, rising edge
//   i_reset      asynchronous active-high reset (clears FSM, outputs, tiles)
//   i_wr_en      write one tile element this cycle (honoured only in IDLE)
//   i_wr_sel     0 = A tile, 1 = B tile
//   i_wr_row     element row index
//   i_wr_col     element column index
//   i_wr_data    element value
//   i_start      begin a feed (honoured only in IDLE)
//   o_busy       high while feeding or draining
//   o_done       one-cycle completion pulse
//   o_a_feed     lane i carries row i of A
//   o_valid_a    per-lane valid for o_a_feed
//   o_b_feed     lane j carries column j of B
//   o_valid_b    per-lane valid for o_b_feed
// ---------------------------------------------------------------------------
module systolic_feeder #(
  parameter int SIZE  = 4,
  parameter int DW    = 8,
  parameter int DRAIN = SIZE + 1
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_wr_en,
  input  logic                          i_wr_sel,
  input  logic [$clog2(SIZE)-1:0]       i_wr_row,
  input  logic [$clog2(SIZE)-1:0]       i_wr_col,
  input  logic [DW-1:0]                 i_wr_data,
  input  logic                          i_start,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [SIZE-1:0][DW-1:0]       o_a_feed,
  output logic [SIZE-1:0]               o_valid_a,
  output logic [SIZE-1:0][DW-1:0]       o_b_feed,
  output logic [SIZE-1:0]               o_valid_b
);

  localparam int IW  = $clog2(SIZE);
  localparam int TW  = $clog2(2 * SIZE);
  localparam int DCW = $clog2(DRAIN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [TW-1:0]    r_t;
  logic [TW-1:0]    w_t_next;
  logic [DCW-1:0]   r_dcnt;
  logic [DCW-1:0]   w_dcnt_next;

  logic [DW-1:0]    r_a [SIZE][SIZE];
  logic [DW-1:0]    r_b [SIZE][SIZE];

  // Tile contents as they will be after this cycle's write. A write in the
  // same IDLE cycle as i_start must reach the first feed step, which is
  // registered on that same edge, so the write data is bypassed here.
  logic [DW-1:0]    w_a_rd [SIZE][SIZE];
  logic [DW-1:0]    w_b_rd [SIZE][SIZE];

  logic                    w_wr_commit;
  logic [SIZE-1:0][DW-1:0] w_a_feed_next;
  logic [SIZE-1:0][DW-1:0] w_b_feed_next;
  logic [SIZE-1:0]         w_valid_a_next;
  logic [SIZE-1:0]         w_valid_b_next;

  assign w_wr_commit = i_wr_en && (r_state == S_IDLE);

  genvar gi, gk;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_row
      for (gk = 0; gk < SIZE; gk++) begin : g_col
        logic w_hit;
        assign w_hit = w_wr_commit && (i_wr_row == IW'(gi)) && (i_wr_col == IW'(gk));
        assign w_a_rd[gi][gk] = (w_hit && !i_wr_sel) ? i_wr_data : r_a[gi][gk];
        assign w_b_rd[gi][gk] = (w_hit &&  i_wr_sel) ? i_wr_data : r_b[gi][gk];
      end
    end
  endgenerate

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_t_next     = r_t;
    w_dcnt_next  = r_dcnt;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next = S_FEED;
          w_t_next     = '0;
        end
      end
      S_FEED: begin
        if (r_t == TW'(2 * SIZE - 2)) begin
          w_state_next = S_DRAIN;
          w_dcnt_next  = '0;
        end else begin
          w_t_next = r_t + TW'(1);
        end
      end
      S_DRAIN: begin
        if (r_dcnt == DCW'(DRAIN - 1)) begin
          w_state_next = S_DONE;
        end else begin
          w_dcnt_next = r_dcnt + DCW'(1);
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Skewed feed for the step that will be presented next cycle. Lane i shows
  // element k exactly when step == i + k, which is unique for each lane.
  always_comb begin
    w_a_feed_next  = '0;
    w_b_feed_next  = '0;
    w_valid_a_next = '0;
    w_valid_b_next = '0;
    if (w_state_next == S_FEED) begin
      for (int i = 0; i < SIZE; i++) begin
        for (int k = 0; k < SIZE; k++) begin
          if (w_t_next == TW'(i + k)) begin
            w_a_feed_next[i]  = w_a_rd[i][k];
            w_valid_a_next[i] = 1'b1;
            w_b_feed_next[i]  = w_b_rd[k][i];
            w_valid_b_next[i] = 1'b1;
          end
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_t       <= '0;
      r_dcnt    <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_a_feed  <= '0;
      o_b_feed  <= '0;
      o_valid_a <= '0;
      o_valid_b <= '0;
    end else begin
      r_state   <= w_state_next;
      r_t       <= w_t_next;
      r_dcnt    <= w_dcnt_next;
      o_busy    <= (w_state_next == S_FEED) || (w_state_next == S_DRAIN);
      o_done    <= (w_state_next == S_DONE);
      o_a_feed  <= w_a_feed_next;
      o_b_feed  <= w_b_feed_next;
      o_valid_a <= w_valid_a_next;
      o_valid_b <= w_valid_b_next;
    end
  end

  // Tile buffers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < SIZE; i++) begin
        for (int k = 0; k < SIZE; k++) begin
          r_a[i][k] <= '0;
          r_b[i][k] <= '0;
        end
      end
    end else if (w_wr_commit) begin
      if (i_wr_sel) begin
        r_b[i_wr_row][i_wr_col] <= i_wr_data;
      end else begin
        r_a[i_wr_row][i_wr_col] <= i_wr_data;
      end
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_feeder
//
// Directed bench for systolic_feeder (SIZE=4, DW=8, DRAIN=5). Feed cycles are
// compared against expected streams built from the bench's own copy of the
// tiles; a small behavioural systolic MAC array checks the end-to-end product.
// ---------------------------------------------------------------------------
module tb_systolic_feeder;

  localparam int SIZE  = 4;
  localparam int DW    = 8;
  localparam int DRAIN = SIZE + 1;

  logic                    i_clk = 1'b0;
  logic                    i_reset;
  logic                    i_wr_en;
  logic                    i_wr_sel;
  logic [1:0]              i_wr_row;
  logic [1:0]              i_wr_col;
  logic [DW-1:0]           i_wr_data;
  logic                    i_start;
  logic                    o_busy;
  logic                    o_done;
  logic [SIZE-1:0][DW-1:0] o_a_feed;
  logic [SIZE-1:0]         o_valid_a;
  logic [SIZE-1:0][DW-1:0] o_b_feed;
  logic [SIZE-1:0]         o_valid_b;

  int checks = 0;
  int errors = 0;

  // Bench copy of the tile contents
  int ea [SIZE][SIZE];
  int eb [SIZE][SIZE];

  systolic_feeder #(.SIZE(SIZE), .DW(DW), .DRAIN(DRAIN)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_wr_en   (i_wr_en),
    .i_wr_sel  (i_wr_sel),
    .i_wr_row  (i_wr_row),
    .i_wr_col  (i_wr_col),
    .i_wr_data (i_wr_data),
    .i_start   (i_start),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_a_feed  (o_a_feed),
    .o_valid_a (o_valid_a),
    .o_b_feed  (o_b_feed),
    .o_valid_b (o_valid_b)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural systolic MAC array: a flows right, b flows down.
  logic [DW-1:0] pa  [SIZE][SIZE];
  logic [DW-1:0] pb  [SIZE][SIZE];
  logic          pva [SIZE][SIZE];
  logic          pvb [SIZE][SIZE];
  logic [DW-1:0] in_a  [SIZE][SIZE];
  logic [DW-1:0] in_b  [SIZE][SIZE];
  logic          in_va [SIZE][SIZE];
  logic          in_vb [SIZE][SIZE];
  int            acc [SIZE][SIZE];

  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        in_a[i][j]  = (j == 0) ? o_a_feed[i]  : pa[i][j-1];
        in_va[i][j] = (j == 0) ? o_valid_a[i] : pva[i][j-1];
        in_b[i][j]  = (i == 0) ? o_b_feed[j]  : pb[i-1][j];
        in_vb[i][j] = (i == 0) ? o_valid_b[j] : pvb[i-1][j];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        if (i_reset) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          pva[i][j] <= 1'b0;
          pvb[i][j] <= 1'b0;
          acc[i][j] <= 0;
        end else begin
          pa[i][j]  <= in_a[i][j];
          pb[i][j]  <= in_b[i][j];
          pva[i][j] <= in_va[i][j];
          pvb[i][j] <= in_vb[i][j];
          if (in_va[i][j] && in_vb[i][j])
            acc[i][j] <= acc[i][j] + int'(in_a[i][j]) * int'(in_b[i][j]);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; returns 1 time unit after the rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic write_elem(input logic sel, input int row, input int col, input int data);
    i_wr_en   = 1'b1;
    i_wr_sel  = sel;
    i_wr_row  = 2'(row);
    i_wr_col  = 2'(col);
    i_wr_data = DW'(data);
    step();
    i_wr_en   = 1'b0;
    if (sel) eb[row][col] = data;
    else     ea[row][col] = data;
  endtask

  task automatic clear_model();
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < SIZE; k++) begin
        ea[i][k] = 0;
        eb[i][k] = 0;
      end
  endtask

  // Expected outputs in cycle c counted from the start sample (cycle 0).
  task automatic check_cycle(input int c);
    logic [SIZE-1:0][DW-1:0] exp_a, exp_b;
    logic [SIZE-1:0]         exp_va, exp_vb;
    int k;
    exp_a = '0; exp_b = '0; exp_va = '0; exp_vb = '0;
    for (int i = 0; i < SIZE; i++) begin
      k = c - 1 - i;
      if (k >= 0 && k < SIZE) begin
        exp_a[i]  = DW'(ea[i][k]);
        exp_va[i] = 1'b1;
        exp_b[i]  = DW'(eb[k][i]);
        exp_vb[i] = 1'b1;
      end
    end
    chk($sformatf("busy c%0d", c),    64'(o_busy),    64'(c >= 1 && c <= 2*SIZE+DRAIN-1));
    chk($sformatf("done c%0d", c),    64'(o_done),    64'(c == 2*SIZE+DRAIN));
    chk($sformatf("a_feed c%0d", c),  64'(o_a_feed),  64'(exp_a));
    chk($sformatf("valid_a c%0d", c), 64'(o_valid_a), 64'(exp_va));
    chk($sformatf("b_feed c%0d", c),  64'(o_b_feed),  64'(exp_b));
    chk($sformatf("valid_b c%0d", c), 64'(o_valid_b), 64'(exp_vb));
  endtask

  // Start a run from IDLE and check cycles 1..14. If poke_cycle > 0, drive an
  // ignored start plus a write of A[0][0]=99 during that cycle. Ends in
  // cycle 14 (IDLE), where the caller may drive the next start.
  task automatic run_and_check(input int poke_cycle, input logic spot);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int c = 1; c <= 2*SIZE+DRAIN; c++) begin
      check_cycle(c);
      if (spot && c == 1) begin
        chk("spot c1 a_feed", 64'(o_a_feed), 64'h0);
        chk("spot c1 valid_a", 64'(o_valid_a), 64'b0001);
      end
      if (spot && c == 4) begin
        chk("spot c4 a0", 64'(o_a_feed[0]), 64'd3);
        chk("spot c4 a3", 64'(o_a_feed[3]), 64'd48);
        chk("spot c4 b3", 64'(o_b_feed[3]), 64'd3);
        chk("spot c4 valids", 64'({o_valid_a, o_valid_b}), 64'hFF);
      end
      if (spot && c == 7) begin
        chk("spot c7 valid_a", 64'(o_valid_a), 64'b1000);
        chk("spot c7 a3", 64'(o_a_feed[3]), 64'd51);
      end
      if (c == poke_cycle) begin
        i_start   = 1'b1;
        i_wr_en   = 1'b1;
        i_wr_sel  = 1'b0;
        i_wr_row  = 2'd0;
        i_wr_col  = 2'd0;
        i_wr_data = 8'd99;
      end
      step();
      i_start = 1'b0;
      i_wr_en = 1'b0;
    end
    chk("idle busy c14", 64'(o_busy), 64'd0);
    chk("idle done c14", 64'(o_done), 64'd0);
  endtask

  initial begin
    i_reset = 1'b1; i_wr_en = 1'b0; i_wr_sel = 1'b0; i_wr_row = '0;
    i_wr_col = '0; i_wr_data = '0; i_start = 1'b0;
    clear_model();

    // Reset with random inputs: everything held at 0
    for (int n = 0; n < 4; n++) begin
      i_wr_en = 1'($urandom); i_wr_sel = 1'($urandom); i_wr_row = 2'($urandom);
      i_wr_col = 2'($urandom); i_wr_data = 8'($urandom); i_start = 1'($urandom);
      step();
      chk("reset busy", 64'(o_busy), 64'd0);
      chk("reset done", 64'(o_done), 64'd0);
      chk("reset feeds", 64'({o_a_feed, o_b_feed}), 64'd0);
      chk("reset valids", 64'({o_valid_a, o_valid_b}), 64'd0);
    end
    i_wr_en = 1'b0; i_start = 1'b0;
    i_reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("post-reset busy", 64'(o_busy), 64'd0);
    end
    $display("reset checks done");

    // Skew pattern tiles
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < SIZE; k++) begin
        write_elem(1'b0, i, k, 16*i + k);
        write_elem(1'b1, i, k, 16*i + k);
      end
    $display("tiles loaded: A[i][k]=16i+k, B[k][j]=16k+j");

    // Run 1 with ignored start + write in cycle 3; run 2 replays from cycle 14
    run_and_check(3, 1'b1);
    $display("run 1 (skew, ignored start/write) checked");
    run_and_check(0, 1'b1);
    $display("run 2 (replay) checked");

    // Reset mid-run in cycle 5
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int c = 1; c < 5; c++) step();
    #2;
    i_reset = 1'b1;
    #1;
    chk("midreset busy", 64'(o_busy), 64'd0);
    chk("midreset done", 64'(o_done), 64'd0);
    chk("midreset feeds", 64'({o_a_feed, o_b_feed}), 64'd0);
    chk("midreset valids", 64'({o_valid_a, o_valid_b}), 64'd0);
    step();
    i_reset = 1'b0;
    clear_model();
    for (int n = 0; n < 12; n++) begin
      step();
      chk($sformatf("no done after abort n%0d", n), 64'({o_done, o_busy}), 64'd0);
    end
    run_and_check(0, 1'b0);
    $display("reset mid-run checked, buffers replay as zero");

    // End-to-end product with identity A
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    clear_model();
    for (int i = 0; i < SIZE; i++)
      write_elem(1'b0, i, i, 1);
    for (int k = 0; k < SIZE; k++)
      for (int j = 0; j < SIZE; j++)
        write_elem(1'b1, k, j, 4*k + j + 1);
    run_and_check(0, 1'b0);
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        chk($sformatf("array out[%0d][%0d]", i, j), 64'(acc[i][j]), 64'(4*i + j + 1));
    $display("end-to-end identity product checked");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Operand scheduler that drives the `SIZE`×`SIZE` systolic MAC array. It buffers one A tile and one B tile, written element by element. On `start`, it streams them into the array in skewed wavefront order: row i of A is delayed i cycles and column j of B is delayed j cycles, with per-lane valid flags. It then waits a fixed drain interval and pulses `done` once the array accumulators hold A·B.

## Interface
- `SIZE`, 4, array dimension (≥2); tiles are `SIZE`×`SIZE`.
- `DW`, 8, operand width; must match array operand width.
- `DRAIN`, `SIZE`+1, cycles waited after the last operand before `done`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and buffers.
- `wr_en`  in  1  write one tile element this cycle.
- `wr_sel`  in  1  0 = A buffer, 1 = B buffer.
- `wr_row`, `wr_col`  in  $clog2(SIZE) each  element index.
- `wr_data`  in  DW  element value.
- `start`  in  1  begin feed; honoured only in IDLE.
- `busy`  out  1  high in FEED and DRAIN.
- `done`  out  1  one-cycle pulse at completion.
- `a_feed`  out  DW×[SIZE]  to array `a_in`; lane i = row i of A.
- `valid_a`  out  1×[SIZE]  to array `valid_a`.
- `b_feed`  out  DW×[SIZE]  to array `b_in`; lane j = column j of B.
- `valid_b`  out  1×[SIZE]  to array `valid_b`.

## Operation
- Storage: two `SIZE`×`SIZE`×`DW` register buffers, A and B. Reset clears them to 0.
- Writes: `wr_en` in IDLE writes `wr_data` to `buf[wr_sel][wr_row][wr_col]`. Writes while `busy` or during the done cycle are ignored.
- FSM: IDLE → FEED → DRAIN → DONE → IDLE.
  - IDLE: `start`=1 → FEED, with t cleared to 0.
  - FEED: t counts 0 .. 2·SIZE−2. At t=2·SIZE−2 → DRAIN, with the drain counter cleared.
  - DRAIN: counts DRAIN cycles, then → DONE.
  - DONE: lasts one cycle, then → IDLE.
- Skew rule, for feed step t:
  - Lane i: k = t−i. If 0 ≤ k < SIZE, `a_feed[i]` = A[i][k] and `valid_a[i]` = 1; otherwise `a_feed[i]` = 0 and `valid_a[i]` = 0.
  - Lane j: k = t−j. If 0 ≤ k < SIZE, `b_feed[j]` = B[k][j] and `valid_b[j]` = 1; otherwise 0 and 0.
- Outside FEED, all `a_feed`, `b_feed`, `valid_a` and `valid_b` are 0.
- A `start` while not in IDLE is ignored; it is not queued.
- `start` and `wr_en` in the same IDLE cycle: the write commits and is visible to the feed.
- Buffers are not modified by feeding, so back-to-back `start`s replay the same tiles.
- Accumulator clearing between tiles is not this block's job; the array accumulates across runs until `reset`.

## Timing
- All outputs are registered. Reset values: `busy`=0, `done`=0, all feed data and valid lanes 0, FSM in IDLE.
- Numbering: `start` is sampled high at the edge ending cycle 0.
- Cycles 1 .. 2·SIZE−1: outputs present feed steps t = 0 .. 2·SIZE−2, i.e. step t appears in cycle t+1. `busy`=1.
- Cycles 2·SIZE .. 2·SIZE+DRAIN−1: DRAIN. `busy`=1, all valid lanes 0.
- Cycle 2·SIZE+DRAIN: `done`=1 and `busy`=0.
- Next cycle: IDLE; a new `start` is accepted.
- Example, SIZE=4 and DRAIN=5: feed in cycles 1–7, drain in cycles 8–12, `done` in cycle 13.
- `reset` asserted mid-FEED or mid-DRAIN: outputs go to 0 immediately (asynchronous) and the FSM returns to IDLE. `done` is never produced for the aborted run. Buffers are cleared.
- `valid_a[i]` is high for exactly SIZE consecutive cycles, cycles i+1 .. i+SIZE. The same holds for `valid_b[j]` over cycles j+1 .. j+SIZE.

## Test plan
- Reset values: assert `reset` with random inputs → all outputs 0; after release, `busy`=0 until `start`.
- Skew pattern: SIZE=4, A[i][k]=16i+k, B[k][j]=16k+j.
  - Cycle 1: `a_feed`={0,0,0,0}, `valid_a`={1,0,0,0}.
  - Cycle 4: `a_feed[0]`=3, `a_feed[3]`=48, `b_feed[3]`=3, all valid=1.
  - Cycle 7: only lane 3 valid, `a_feed[3]`=51.
- Done timing: SIZE=4, DRAIN=5, `start` in cycle 0 → `busy` high in cycles 1–12; `done` is a single pulse in cycle 13.
- Ignored inputs: `start` and `wr_en` (A[0][0]=99) in cycle 3 → no restart, buffer unchanged, `done` still in cycle 13. A second `start` in cycle 14 replays identical streams.
- Reset mid-run: assert `reset` in cycle 5 → outputs 0 in that cycle, no `done` pulse, buffers read back 0 on the next run.
- End-to-end with the array: fresh reset, A = identity, B[k][j]=4k+j+1 → array `out[i][j]`=4i+j+1 for all i,j when sampled at `done`.
